// File: rtl/ann_layer_engine.sv
// ann_layer_engine: one neural-network layer, y[j] = sat((sum x[i]*w[j][i] + b[j]) >>> FRAC).
// Define LAYER_RELU_EN to clamp negative results to zero (ReLU); otherwise identity activation.
module ann_layer_engine #(
  parameter int N_IN  = 62,
  parameter int N_OUT = 30,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int FRAC  = 4,
  localparam int XAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WAW  = $clog2(N_OUT * (N_IN + 1)),
  localparam int YAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IW   = $clog2(N_IN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_ann,
  output logic           layer_ready,
  output logic           busy,
  output logic [XAW-1:0] x_addr,
  input  logic [DW-1:0]  x_data,
  output logic [WAW-1:0] w_addr,
  input  logic [DW-1:0]  w_data,
  output logic           y_we,
  output logic [YAW-1:0] y_addr,
  output logic [DW-1:0]  y_data
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_WRITE, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IW-1:0]            r_i;
  logic [YAW-1:0]           r_j;
  logic [WAW-1:0]           r_waddr;
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_last;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DW-1:0]            w_act;

  assign w_last     = (r_j == YAW'(N_OUT - 1));
  assign w_prod     = $signed(x_data) * $signed(w_data);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_bias_ext = ACC_W'($signed(w_data));
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    w_act = w_shift[DW-1:0];
    if (w_shift > SAT_MAX) begin
      w_act = SAT_MAX[DW-1:0];
    end else if (w_shift < 0) begin
`ifdef LAYER_RELU_EN
      w_act = '0;
`else
      if (w_shift < SAT_MIN) w_act = SAT_MIN[DW-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_ann) w_state_next = S_MAC;
      S_MAC:   if (r_i == IW'(N_IN)) w_state_next = S_BIAS;
      S_BIAS:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_MAC;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    layer_ready = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    y_we        = (r_state == S_WRITE);
    y_data      = y_we ? w_act : '0;
  end

  assign y_addr = r_j;
  assign w_addr = r_waddr;
  assign x_addr = (r_i < IW'(N_IN)) ? XAW'(r_i) : XAW'(N_IN - 1);

  // Data from the address issued at i-1 arrives at i, so the i=0 cycle adds nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= '0;
      r_j     <= '0;
      r_waddr <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_ann) begin
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
          end
        end
        S_MAC: begin
          if (r_i != '0) r_acc <= r_acc + w_prod_ext;
          r_i     <= r_i + IW'(1);
          r_waddr <= r_waddr + WAW'(1);
        end
        S_BIAS: r_acc <= r_acc + w_bias_ext;
        S_WRITE: begin
          r_i   <= '0;
          r_acc <= '0;
          if (w_last) begin
            r_j     <= '0;
            r_waddr <= '0;
          end else begin
            r_j <= r_j + YAW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_layer_engine.sv
// Bench for ann_layer_engine with N_IN=4, N_OUT=2: instance A (FRAC=0) and instance B (FRAC=4).
// Expected writes are queued when a start is issued and popped as y_we strobes appear.
module tb_ann_layer_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       rdy_a, busy_a, ya_we, rdy_b, busy_b, yb_we;
  logic [1:0] xa_addr, xb_addr;
  logic [3:0] wa_addr, wb_addr;
  logic [0:0] ya_addr, yb_addr;
  logic [7:0] ya_data, yb_data;
  logic [7:0] xa_data, wa_data, xb_data, wb_data;

  logic [7:0] x_mem [4];
  logic [7:0] w_mem [16];

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int we_a = 0, we_b = 0, rdy_cnt_a = 0, rdy_cnt_b = 0;
  int c0, we0, r0;

  typedef struct {int addr; int data;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  ann_layer_engine #(.N_IN(4), .N_OUT(2), .DW(8), .ACC_W(24), .FRAC(0)) u_dut_a (
    .clk(clk), .rst(rst), .start_ann(start_a), .layer_ready(rdy_a), .busy(busy_a),
    .x_addr(xa_addr), .x_data(xa_data), .w_addr(wa_addr), .w_data(wa_data),
    .y_we(ya_we), .y_addr(ya_addr), .y_data(ya_data)
  );

  ann_layer_engine #(.N_IN(4), .N_OUT(2), .DW(8), .ACC_W(24), .FRAC(4)) u_dut_b (
    .clk(clk), .rst(rst), .start_ann(start_b), .layer_ready(rdy_b), .busy(busy_b),
    .x_addr(xb_addr), .x_data(xb_data), .w_addr(wb_addr), .w_data(wb_data),
    .y_we(yb_we), .y_addr(yb_addr), .y_data(yb_data)
  );

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    xa_data <= x_mem[xa_addr];
    wa_data <= w_mem[wa_addr];
    xb_data <= x_mem[xb_addr];
    wb_data <= w_mem[wb_addr];
  end

  function automatic int act(input int v);
`ifdef LAYER_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit use_b, input int y0, input int y1);
    exp_t e0, e1;
    e0.addr = 0; e0.data = y0;
    e1.addr = 1; e1.data = y1;
    if (use_b) begin qb.push_back(e0); qb.push_back(e1); end
    else       begin qa.push_back(e0); qa.push_back(e1); end
  endtask

  // Observe both DUTs on the falling edge; every write is one scoreboard transaction.
  task automatic tick();
    @(negedge clk);
    if (ya_we === 1'b1) begin
      we_a++;
      n_cmp++;
      $display("write a cyc=%0d addr=%0d data=%0d", cyc, ya_addr, $signed(ya_data));
      if (qa.size() == 0) begin
        n_mis++;
        $error("FAIL a_write_unexpected observed addr=%0d data=%0d expected none", ya_addr, $signed(ya_data));
      end else begin
        ea = qa.pop_front();
        assert (ya_addr === 1'(ea.addr) && $signed(ya_data) === 8'(ea.data)) else begin
          n_mis++;
          $error("FAIL a_write observed addr=%0d data=%0d expected addr=%0d data=%0d",
                 ya_addr, $signed(ya_data), ea.addr, ea.data);
        end
      end
    end
    if (yb_we === 1'b1) begin
      we_b++;
      n_cmp++;
      $display("write b cyc=%0d addr=%0d data=%0d", cyc, yb_addr, $signed(yb_data));
      if (qb.size() == 0) begin
        n_mis++;
        $error("FAIL b_write_unexpected observed addr=%0d data=%0d expected none", yb_addr, $signed(yb_data));
      end else begin
        eb = qb.pop_front();
        assert (yb_addr === 1'(eb.addr) && $signed(yb_data) === 8'(eb.data)) else begin
          n_mis++;
          $error("FAIL b_write observed addr=%0d data=%0d expected addr=%0d data=%0d",
                 yb_addr, $signed(yb_data), eb.addr, eb.data);
        end
      end
    end
    if (rdy_a === 1'b1) rdy_cnt_a++;
    if (rdy_b === 1'b1) rdy_cnt_b++;
  endtask

  task automatic step();
    tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit use_b, output int c_start);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    c_start = cyc;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_ready(input bit use_b, input int c_start, input string tag);
    bit seen = 1'b0;
    int lat = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if ((use_b ? rdy_b : rdy_a) === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - c_start;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    assert (seen && lat === 15) else begin
      n_mis++;
      $error("FAIL %s latency observed=%0d (seen=%0d) expected=15", tag, lat, seen);
    end
  endtask

  task automatic load_basic();
    for (int k = 0; k < 16; k++) w_mem[k] = 8'd0;
    for (int k = 0; k < 4; k++) begin
      x_mem[k]     = 8'(k + 1);
      w_mem[k]     = 8'(1);
      w_mem[5 + k] = 8'(-1);
    end
    w_mem[4] = 8'(0);
    w_mem[9] = 8'(-2);
  endtask

  initial begin
    load_basic();
    @(posedge clk);
    #1;

    // Reset, with start asserted during reset to confirm reset has priority.
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    rst     = 1'b0;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ready", 32'(rdy_a), 0);
    check("rst_we", 32'(ya_we), 0);
    check("rst_addrs", 32'({xa_addr, wa_addr, ya_addr}), 0);
    check("rst_ydata", 32'(ya_data), 0);
    step();
    check("rst_start_dropped", 32'(busy_a), 0);

    // Basic layer, then a back-to-back start in the cycle after layer_ready.
    we0 = we_a;
    push(0, 10, act(-12));
    pulse_start(0, c0);
    check("busy_after_start", 32'(busy_a), 1);
    wait_ready(0, c0, "basic_latency");
    check("basic_queue_drained", 32'(qa.size()), 0);
    push(0, 10, act(-12));
    pulse_start(0, c0);
    check("b2b_accepted_busy", 32'(busy_a), 1);
    wait_ready(0, c0, "b2b_latency");
    check("b2b_we_count", 32'(we_a - we0), 4);

    // Extra start pulses at cycles 3 and 9 must be ignored.
    we0 = we_a;
    r0  = rdy_cnt_a;
    push(0, 10, act(-12));
    pulse_start(0, c0);
    step();
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (5) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_ready(0, c0, "busy_start_latency");
    repeat (25) step();
    check("busy_start_we_count", 32'(we_a - we0), 2);
    check("busy_start_ready_count", 32'(rdy_cnt_a - r0), 1);
    check("busy_start_idle", 32'(busy_a), 0);

    // Reset at cycle 5 aborts the layer; a fresh start then works normally.
    we0 = we_a;
    r0  = rdy_cnt_a;
    pulse_start(0, c0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy_a), 0);
    repeat (30) step();
    check("abort_no_we", 32'(we_a - we0), 0);
    check("abort_no_ready", 32'(rdy_cnt_a - r0), 0);
    push(0, 10, act(-12));
    pulse_start(0, c0);
    wait_ready(0, c0, "after_abort_latency");
    check("after_abort_drained", 32'(qa.size()), 0);

    // FRAC=4 instance: arithmetic shift rounds toward minus infinity (-168 >>> 4 = -11).
    for (int k = 0; k < 4; k++) begin
      w_mem[k]     = 8'(16);
      w_mem[5 + k] = 8'(-16);
    end
    w_mem[4] = 8'(8);
    w_mem[9] = 8'(-8);
    push(1, 10, act(-11));
    pulse_start(1, c0);
    wait_ready(1, c0, "frac4_latency");

    // Saturation: positive on neuron 0, negative on neuron 1, in both instances.
    for (int k = 0; k < 4; k++) begin
      x_mem[k]     = 8'(127);
      w_mem[k]     = 8'(127);
      w_mem[5 + k] = 8'(-128);
    end
    w_mem[4] = 8'(0);
    w_mem[9] = 8'(0);
    push(0, 127, act(-128));
    pulse_start(0, c0);
    wait_ready(0, c0, "sat_a_latency");
    push(1, 127, act(-128));
    pulse_start(1, c0);
    wait_ready(1, c0, "sat_b_latency");
    check("sat_queues_drained", 32'(qa.size() + qb.size()), 0);
    check("b_we_count", 32'(we_b), 4);
    check("b_ready_count", 32'(rdy_cnt_b), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
